// File: rtl/ysyx_22040895_id_stage_if.sv
// ysyx_22040895_id_stage_if
// Bundles the fetch-side and decode-side handshake and data signals of the
// instruction-decode stage.
//   master : environment side (fetch + downstream consumer). Drives flush,
//            in_valid/pc/inst and out_ready. Sees in_ready and the head entry.
//   slave  : the decode stage itself.
// Parameters: PC_W (PC width), INST_W (instruction width, 32 for RV base).
interface ysyx_22040895_id_stage_if #(
  parameter int PC_W   = 64,
  parameter int INST_W = 32
);
  logic              flush_i;
  logic              in_valid_i;
  logic              in_ready_o;
  logic [PC_W-1:0]   pc_i;
  logic [INST_W-1:0] inst_i;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [PC_W-1:0]   pc_o;
  logic [INST_W-1:0] inst_o;
  logic [4:0]        rs1_o;
  logic [4:0]        rs2_o;
  logic [4:0]        rd_o;
  logic              immsel_o;
  logic [11:0]       imm1_o;
  logic [19:0]       imm2_o;
  logic              illegal_o;

  modport master (
    output flush_i, in_valid_i, pc_i, inst_i, out_ready_i,
    input  in_ready_o, out_valid_o, pc_o, inst_o, rs1_o, rs2_o, rd_o,
           immsel_o, imm1_o, imm2_o, illegal_o
  );

  modport slave (
    input  flush_i, in_valid_i, pc_i, inst_i, out_ready_i,
    output in_ready_o, out_valid_o, pc_o, inst_o, rs1_o, rs2_o, rd_o,
           immsel_o, imm1_o, imm2_o, illegal_o
  );
endinterface

// File: rtl/ysyx_22040895_id_stage.sv
// ysyx_22040895_id_stage
// Instruction-decode pipeline stage. Accepts {pc, inst} from fetch over a
// valid/ready handshake, decodes the raw immediate fields and register
// indices, and holds up to two decoded entries (main + skid) so that
// in_ready never depends combinationally on out_ready.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset, drops all entries
//   bus  : ysyx_22040895_id_stage_if.slave (flush, input handshake,
//          output handshake, head-entry fields rs1/rs2/rd, immsel, imm1,
//          imm2, illegal)
// Optional feature macro: YSYX_22040895_ILLEGAL_DET_EN
//   defined   -> unrecognised opcodes set a stored illegal bit, reported
//                on illegal_o for the head entry
//   undefined -> illegal_o is tied to 0 and no bit is stored
module ysyx_22040895_id_stage #(
  parameter int PC_W   = 64,
  parameter int INST_W = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  ysyx_22040895_id_stage_if.slave       bus
);

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [4:0]        rd;
    logic              immsel;
    logic [11:0]       imm1;
    logic [19:0]       imm2;
`ifdef YSYX_22040895_ILLEGAL_DET_EN
    logic              illegal;
`endif
  } entry_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t state_q, state_d;
  entry_t main_q, skid_q;
  entry_t dec;
  entry_t head;

  logic in_ready;
  logic out_valid;
  logic accept;
  logic pop;
  logic load_main_in;
  logic load_main_skid;
  logic load_skid;

  // Decode straight off the fetch bus; the result is stored with the entry.
  always_comb begin
    dec        = '0;
    dec.pc     = bus.pc_i;
    dec.inst   = bus.inst_i;
    dec.rs1    = bus.inst_i[19:15];
    dec.rs2    = bus.inst_i[24:20];
    dec.rd     = bus.inst_i[11:7];
    dec.immsel = 1'b1;
    case (bus.inst_i[6:0])
      7'b0000011, 7'b0010011, 7'b0011011, 7'b1100111, 7'b1110011: begin
        dec.imm1 = bus.inst_i[31:20];
      end
      7'b0100011: begin
        dec.imm1 = {bus.inst_i[31:25], bus.inst_i[11:7]};
      end
      // Branch offset is kept halved; the consumer appends the zero LSB.
      7'b1100011: begin
        dec.imm1 = {bus.inst_i[31], bus.inst_i[7], bus.inst_i[30:25], bus.inst_i[11:8]};
      end
      7'b0110111, 7'b0010111: begin
        dec.immsel = 1'b0;
        dec.imm2   = bus.inst_i[31:12];
      end
      // Jump offset is kept halved as well.
      7'b1101111: begin
        dec.immsel = 1'b0;
        dec.imm2   = {bus.inst_i[31], bus.inst_i[19:12], bus.inst_i[20], bus.inst_i[30:21]};
      end
      7'b0110011, 7'b0111011: begin
        dec.immsel = 1'b1;
      end
      default: begin
        dec.immsel = 1'b1;
`ifdef YSYX_22040895_ILLEGAL_DET_EN
        dec.illegal = 1'b1;
`endif
      end
    endcase
  end

  // Ready depends only on occupancy, never on out_ready.
  assign in_ready  = !rst && (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign accept    = bus.in_valid_i & in_ready;
  assign pop       = out_valid & bus.out_ready_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Flush wins over everything: an accept in the same cycle is dropped,
  // a pop in the same cycle has already been taken by downstream.
  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (bus.flush_i) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d      = ONE;
            load_main_in = 1'b1;
          end
        end
        ONE: begin
          if (accept && pop) begin
            load_main_in = 1'b1;
          end else if (accept) begin
            state_d   = FULL;
            load_skid = 1'b1;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            state_d        = ONE;
            load_main_skid = 1'b1;
          end
        end
        default: begin
          state_d = EMPTY;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main_in) begin
        main_q <= dec;
      end else if (load_main_skid) begin
        main_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= dec;
      end
    end
  end

  // Stale main contents are masked so the outputs read zero when empty.
  assign head = out_valid ? main_q : '0;

  assign bus.in_ready_o  = in_ready;
  assign bus.out_valid_o = out_valid;
  assign bus.pc_o        = head.pc;
  assign bus.inst_o      = head.inst;
  assign bus.rs1_o       = head.rs1;
  assign bus.rs2_o       = head.rs2;
  assign bus.rd_o        = head.rd;
  assign bus.immsel_o    = head.immsel;
  assign bus.imm1_o      = head.imm1;
  assign bus.imm2_o      = head.imm2;
`ifdef YSYX_22040895_ILLEGAL_DET_EN
  assign bus.illegal_o   = head.illegal;
`else
  assign bus.illegal_o   = 1'b0;
`endif

endmodule

// File: tb/tb_ysyx_22040895_id_stage.sv
// tb_ysyx_22040895_id_stage
// Scoreboard bench for the decode stage. The driver issues one cycle of
// stimulus at a time and pushes the expected decoded entry for every
// instruction that the stage should accept; a separate monitor compares the
// head entry and the handshake outputs every mid-cycle.
module tb_ysyx_22040895_id_stage;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] inst;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        immsel;
    logic [11:0] imm1;
    logic [19:0] imm2;
    logic        illegal;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  ysyx_22040895_id_stage_if #(.PC_W(64), .INST_W(32)) bus ();

  ysyx_22040895_id_stage #(.PC_W(64), .INST_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   rd_idx    = 0;
  int   drop_upto = 0;
  int   total     = 0;
  int   bad       = 0;

  logic pend_push = 1'b0;
  logic pend_drop = 1'b0;
  exp_t pend_e;

  logic [6:0] op_tab [14] = '{7'b0000011, 7'b0010011, 7'b0011011, 7'b1100111,
                              7'b1110011, 7'b0100011, 7'b1100011, 7'b0110111,
                              7'b0010111, 7'b1101111, 7'b0110011, 7'b0111011,
                              7'b0001111, 7'b1111111};

  // Reference decode: immediates are rebuilt as full byte offsets and then
  // reduced to the raw field widths the consumer expects.
  function automatic exp_t refModel(input logic [63:0] pc, input logic [31:0] inst);
    exp_t        e;
    logic [12:0] b_off;
    logic [20:0] j_off;
    logic        known;
    e.pc      = pc;
    e.inst    = inst;
    e.rs1     = inst[19:15];
    e.rs2     = inst[24:20];
    e.rd      = inst[11:7];
    e.immsel  = 1'b1;
    e.imm1    = 12'h0;
    e.imm2    = 20'h0;
    known     = 1'b1;
    b_off     = {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    j_off     = {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    if (inst[6:0] inside {7'b0000011, 7'b0010011, 7'b0011011, 7'b1100111, 7'b1110011})
      e.imm1 = inst[31:20];
    else if (inst[6:0] == 7'b0100011)
      e.imm1 = {inst[31:25], inst[11:7]};
    else if (inst[6:0] == 7'b1100011)
      e.imm1 = b_off[12:1];
    else if (inst[6:0] inside {7'b0110111, 7'b0010111}) begin
      e.immsel = 1'b0;
      e.imm2   = inst[31:12];
    end else if (inst[6:0] == 7'b1101111) begin
      e.immsel = 1'b0;
      e.imm2   = j_off[20:1];
    end else if (!(inst[6:0] inside {7'b0110011, 7'b0111011}))
      known = 1'b0;
`ifdef YSYX_22040895_ILLEGAL_DET_EN
    e.illegal = !known;
`else
    e.illegal = 1'b0;
`endif
    return e;
  endfunction

  function automatic int occupancy();
    int r;
    r = (rd_idx > drop_upto) ? rd_idx : drop_upto;
    return exp_q.size() - r;
  endfunction

  task automatic checkOutput(input string nm, input logic [63:0] act, input logic [63:0] want);
    total = total + 1;
    if (act !== want) begin
      bad = bad + 1;
      $display("[TB] FAIL %s: got %0h want %0h (t=%0t)", nm, act, want, $time);
    end
  endtask

  task automatic commitPending();
    if (pend_drop)
      drop_upto = exp_q.size();
    else if (pend_push)
      exp_q.push_back(pend_e);
    pend_drop = 1'b0;
    pend_push = 1'b0;
  endtask

  // One cycle of stimulus; the expected entry is queued at the edge that
  // accepts it so the monitor always sees the stage's true occupancy.
  task automatic applyStimulus(input logic v, input logic [63:0] pc, input logic [31:0] inst,
                               input logic ordy, input logic fl);
    int occ;
    @(posedge clk);
    commitPending();
    #1;
    bus.in_valid_i  = v;
    bus.pc_i        = pc;
    bus.inst_i      = inst;
    bus.out_ready_i = ordy;
    bus.flush_i     = fl;
    occ       = occupancy();
    pend_drop = fl;
    pend_push = v && !fl && (occ < 2);
    pend_e    = refModel(pc, inst);
  endtask

  task automatic resetMidStream();
    @(posedge clk);
    commitPending();
    #1;
    bus.in_valid_i  = 1'b0;
    bus.out_ready_i = 1'b0;
    bus.flush_i     = 1'b0;
    #2;
    rst       = 1'b1;
    drop_upto = exp_q.size();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  function automatic logic [31:0] randInst();
    logic [31:0] r;
    int          k;
    r = $urandom;
    k = $urandom_range(0, 15);
    if (k < 14)
      r[6:0] = op_tab[k];
    return r;
  endfunction

  function automatic logic [63:0] randPc();
    logic [31:0] hi;
    logic [31:0] lo;
    hi = $urandom;
    lo = $urandom;
    return {hi, lo[31:2], 2'b00};
  endfunction

  // Monitor: mid-cycle comparison of handshake and head entry.
  initial begin
    exp_t e;
    int   occ;
    forever begin
      @(negedge clk);
      if (rd_idx < drop_upto)
        rd_idx = drop_upto;
      occ = exp_q.size() - rd_idx;
      if (rst) begin
        checkOutput("rst_out_valid", 64'(bus.out_valid_o), 64'd0);
        checkOutput("rst_in_ready", 64'(bus.in_ready_o), 64'd0);
        checkOutput("rst_pc", bus.pc_o, 64'd0);
        checkOutput("rst_inst", 64'(bus.inst_o), 64'd0);
        checkOutput("rst_imm1", 64'(bus.imm1_o), 64'd0);
      end else begin
        checkOutput("in_ready", 64'(bus.in_ready_o), 64'(occ < 2));
        checkOutput("out_valid", 64'(bus.out_valid_o), 64'(occ > 0));
        if (occ > 0) begin
          e = exp_q[rd_idx];
          checkOutput("pc", bus.pc_o, e.pc);
          checkOutput("inst", 64'(bus.inst_o), 64'(e.inst));
          checkOutput("rs1", 64'(bus.rs1_o), 64'(e.rs1));
          checkOutput("rs2", 64'(bus.rs2_o), 64'(e.rs2));
          checkOutput("rd", 64'(bus.rd_o), 64'(e.rd));
          checkOutput("immsel", 64'(bus.immsel_o), 64'(e.immsel));
          checkOutput("imm1", 64'(bus.imm1_o), 64'(e.imm1));
          checkOutput("imm2", 64'(bus.imm2_o), 64'(e.imm2));
          checkOutput("illegal", 64'(bus.illegal_o), 64'(e.illegal));
          if (bus.out_ready_i)
            rd_idx = rd_idx + 1;
        end else begin
          checkOutput("empty_pc", bus.pc_o, 64'd0);
          checkOutput("empty_inst", 64'(bus.inst_o), 64'd0);
          checkOutput("empty_imm2", 64'(bus.imm2_o), 64'd0);
          checkOutput("empty_rd", 64'(bus.rd_o), 64'd0);
        end
      end
    end
  end

  initial begin
    bus.in_valid_i  = 1'b0;
    bus.out_ready_i = 1'b0;
    bus.flush_i     = 1'b0;
    bus.pc_i        = 64'd0;
    bus.inst_i      = 32'd0;
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    $display("[TB] reset released");

    // addi x1,x2,-1 then lui x5,0x12345, back to back
    applyStimulus(1'b1, 64'h8000_0000, 32'hFFF10093, 1'b1, 1'b0);
    applyStimulus(1'b1, 64'h8000_0004, 32'h123452B7, 1'b1, 1'b0);
    applyStimulus(1'b0, 64'd0, 32'd0, 1'b1, 1'b0);
    applyStimulus(1'b0, 64'd0, 32'd0, 1'b1, 1'b0);

    // back-pressure: third instruction waits until a slot frees
    applyStimulus(1'b1, 64'h100, 32'h00A00513, 1'b0, 1'b0);
    applyStimulus(1'b1, 64'h104, 32'h00B285A3, 1'b0, 1'b0);
    applyStimulus(1'b1, 64'h108, 32'hFE0718E3, 1'b0, 1'b0);
    applyStimulus(1'b1, 64'h108, 32'hFE0718E3, 1'b0, 1'b0);
    applyStimulus(1'b1, 64'h108, 32'hFE0718E3, 1'b1, 1'b0);
    applyStimulus(1'b1, 64'h108, 32'hFE0718E3, 1'b1, 1'b0);
    repeat (3) applyStimulus(1'b0, 64'd0, 32'd0, 1'b1, 1'b0);

    // flush while full with an instruction offered
    applyStimulus(1'b1, 64'h200, 32'h7FF0006F, 1'b0, 1'b0);
    applyStimulus(1'b1, 64'h204, 32'h00000017, 1'b0, 1'b0);
    applyStimulus(1'b1, 64'h208, 32'h00C58633, 1'b0, 1'b1);
    applyStimulus(1'b0, 64'd0, 32'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, 64'd0, 32'd0, 1'b1, 1'b0);

    // unrecognised opcode
    applyStimulus(1'b1, 64'h300, 32'h0000007F, 1'b1, 1'b0);
    applyStimulus(1'b0, 64'd0, 32'd0, 1'b1, 1'b0);

    // asynchronous reset with entries held
    applyStimulus(1'b1, 64'h400, 32'hFFF10093, 1'b0, 1'b0);
    applyStimulus(1'b1, 64'h404, 32'h123452B7, 1'b0, 1'b0);
    resetMidStream();
    applyStimulus(1'b0, 64'd0, 32'd0, 1'b1, 1'b0);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic v;
      logic o;
      logic f;
      v = ($urandom_range(0, 9) < 7);
      o = ($urandom_range(0, 9) < 6);
      f = ($urandom_range(0, 31) == 0);
      applyStimulus(v, randPc(), randInst(), o, f);
    end

    repeat (4) applyStimulus(1'b0, 64'd0, 32'd0, 1'b1, 1'b0);
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
